fetch_stage: RTL and testbench

Instruction-fetch stage feeding the decode stage. Owns the PC and the instruction-memory request handshake, and drives the `fs_ds` pipeline register as `{instr, pc}`. It applies the stall (`load_use`) and branch redirect (`ds_branch_data`) produced by decode, and keeps a one-entry skid buffer so that no accepted fetch is lost during a stall.

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int FS_DATA     = 64;
    localparam int BRANCH_DATA = 33;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Contents of the fetch/decode register when it holds no instruction.
    localparam logic [FS_DATA-1:0] FS_BUBBLE = {NOP_INSTR, 32'h0000_0000};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DROP = 2'd1,
        ST_FULL = 2'd2
    } fs_state_e;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the imem request handshake, a one-entry
// skid buffer for fetches accepted during a stall, and the fetch/decode register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [BRANCH_DATA-1:0] ds_branch_data,
    input  logic                   load_use,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ready,
    input  logic [31:0]            imem_rdata,
    output logic [FS_DATA-1:0]     fs_ds_reg_data,
    output logic                   fs_valid
);

    fs_state_e          r_state;
    logic [31:0]        r_fetch_addr;
    logic [31:0]        r_redirect_pc;
    logic [31:0]        r_skid_instr;
    logic [31:0]        r_skid_pc;
    logic [FS_DATA-1:0] r_fs_ds;
    logic               r_fs_valid;
    logic               r_req;

    fs_state_e          w_state_nx;
    logic [31:0]        w_fetch_addr_nx;
    logic [31:0]        w_redirect_pc_nx;
    logic [31:0]        w_skid_instr_nx;
    logic [31:0]        w_skid_pc_nx;
    logic [FS_DATA-1:0] w_fs_ds_nx;
    logic               w_fs_valid_nx;
    logic               w_req_nx;

    logic               w_branch_taken;
    logic [31:0]        w_target;
    logic               w_redirect;
    logic               w_fire;
    logic [31:0]        w_addr_inc;

    // A stall always beats a branch: its operands are not trustworthy under load_use.
    assign w_branch_taken = ds_branch_data[0];
    assign w_target       = word_align(ds_branch_data[32:1]);
    assign w_redirect     = w_branch_taken & r_fs_valid & ~load_use;
    assign w_fire         = r_req & imem_ready;
    assign w_addr_inc     = r_fetch_addr + 32'd4;

    // Next-state, next-PC, skid buffer and fetch/decode register update.
    always_comb begin
        w_state_nx       = r_state;
        w_fetch_addr_nx  = r_fetch_addr;
        w_redirect_pc_nx = r_redirect_pc;
        w_skid_instr_nx  = r_skid_instr;
        w_skid_pc_nx     = r_skid_pc;
        w_fs_ds_nx       = r_fs_ds;
        w_fs_valid_nx    = r_fs_valid;

        case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    w_fs_ds_nx    = FS_BUBBLE;
                    w_fs_valid_nx = 1'b0;
                    if (w_fire) begin
                        // Accepted data belongs to the wrong path; go straight to the target.
                        w_fetch_addr_nx = w_target;
                    end else begin
                        // Address must stay put until the pending request is accepted.
                        w_redirect_pc_nx = w_target;
                        w_state_nx       = ST_DROP;
                    end
                end else if (load_use) begin
                    if (w_fire) begin
                        w_skid_instr_nx = imem_rdata;
                        w_skid_pc_nx    = r_fetch_addr;
                        w_fetch_addr_nx = w_addr_inc;
                        w_state_nx      = ST_FULL;
                    end else begin
                        w_state_nx = ST_RUN;
                    end
                end else if (w_fire) begin
                    w_fs_ds_nx      = {imem_rdata, r_fetch_addr};
                    w_fs_valid_nx   = 1'b1;
                    w_fetch_addr_nx = w_addr_inc;
                end else begin
                    w_fs_ds_nx    = FS_BUBBLE;
                    w_fs_valid_nx = 1'b0;
                end
            end

            ST_DROP: begin
                w_fs_ds_nx    = FS_BUBBLE;
                w_fs_valid_nx = 1'b0;
                if (w_fire) begin
                    w_fetch_addr_nx = r_redirect_pc;
                    w_state_nx      = ST_RUN;
                end else begin
                    w_state_nx = ST_DROP;
                end
            end

            ST_FULL: begin
                if (w_redirect) begin
                    w_skid_instr_nx = 32'h0000_0000;
                    w_skid_pc_nx    = 32'h0000_0000;
                    w_fetch_addr_nx = w_target;
                    w_fs_ds_nx      = FS_BUBBLE;
                    w_fs_valid_nx   = 1'b0;
                    w_state_nx      = ST_RUN;
                end else if (!load_use) begin
                    w_fs_ds_nx    = {r_skid_instr, r_skid_pc};
                    w_fs_valid_nx = 1'b1;
                    w_state_nx    = ST_RUN;
                end else begin
                    w_state_nx = ST_FULL;
                end
            end

            default: begin
                w_state_nx    = ST_RUN;
                w_fs_ds_nx    = FS_BUBBLE;
                w_fs_valid_nx = 1'b0;
            end
        endcase

        // Requests are issued in every state except while the skid entry is parked.
        w_req_nx = (w_state_nx != ST_FULL);
    end

    // State and datapath registers; the request stays low until the first edge after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_RUN;
            r_fetch_addr  <= RESET_PC;
            r_redirect_pc <= 32'h0000_0000;
            r_skid_instr  <= 32'h0000_0000;
            r_skid_pc     <= 32'h0000_0000;
            r_fs_ds       <= FS_BUBBLE;
            r_fs_valid    <= 1'b0;
            r_req         <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_fetch_addr  <= w_fetch_addr_nx;
            r_redirect_pc <= w_redirect_pc_nx;
            r_skid_instr  <= w_skid_instr_nx;
            r_skid_pc     <= w_skid_pc_nx;
            r_fs_ds       <= w_fs_ds_nx;
            r_fs_valid    <= w_fs_valid_nx;
            r_req         <= w_req_nx;
        end
    end

    assign imem_req       = r_req;
    assign imem_addr      = r_fetch_addr;
    assign fs_ds_reg_data = r_fs_ds;
    assign fs_valid       = r_fs_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: scoreboarded reset stream, a cycle table covering
// stall/redirect/wrap cases, and a hand-written asynchronous reset in DROP.
module tb_fetch_stage;

    localparam logic [31:0] XOR_K = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        resetn;
    logic [32:0] ds_branch_data;
    logic        load_use;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [63:0] fs_ds_reg_data;
    logic        fs_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        lu;
        logic        bt;
        logic [31:0] ba;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs [24];
    logic [63:0] sb_q [$];

    fetch_stage #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_branch_data (ds_branch_data),
        .load_use       (load_use),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .fs_ds_reg_data (fs_ds_reg_data),
        .fs_valid       (fs_valid)
    );

    // Memory model: the instruction word is derived from its address.
    assign imem_rdata = imem_addr ^ XOR_K;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic lu, input logic bt, input logic [31:0] ba,
                                input logic rdy, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] epc);
        vec_t v;
        v.lu = lu; v.bt = bt; v.ba = ba; v.rdy = rdy;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = epc;
        return v;
    endfunction

    function automatic logic [63:0] exp_fs(input logic v, input logic [31:0] pc);
        return v ? {pc ^ XOR_K, pc} : {NOP, 32'h0000_0000};
    endfunction

    task automatic drive(input logic lu, input logic bt, input logic [31:0] ba, input logic rdy);
        load_use       = lu;
        ds_branch_data = {ba, bt};
        imem_ready     = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   64'(imem_req), 64'd0);
        chk({tag, "_addr"},  64'(imem_addr), 64'h8000_0000);
        chk({tag, "_valid"}, 64'(fs_valid), 64'd0);
        chk({tag, "_fs"},    fs_ds_reg_data, {NOP, 32'h0000_0000});
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        step();
        chk("post_reset_req",  64'(imem_req), 64'd1);
        chk("post_reset_addr", 64'(imem_addr), 64'h8000_0000);
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [63:0] popped;

        resetn = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);

        vecs[0]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004);
        vecs[2]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_000C, 1'b1, 32'h8000_0004);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_000C, 1'b1, 32'h8000_0004);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0008);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_000C, 1'b0, 32'h0);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_000C);
        vecs[7]  = mk(1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b1, 32'h8000_0010, 1'b0, 32'h0);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0010, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0104, 1'b1, 32'h8000_0100);
        vecs[11] = mk(1'b1, 1'b1, 32'h8000_0300, 1'b0, 1'b1, 32'h8000_0104, 1'b1, 32'h8000_0100);
        vecs[12] = mk(1'b1, 1'b1, 32'h8000_0300, 1'b1, 1'b0, 32'h8000_0108, 1'b1, 32'h8000_0100);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0108, 1'b1, 32'h8000_0104);
        vecs[14] = mk(1'b0, 1'b1, 32'h8000_0203, 1'b1, 1'b1, 32'h8000_0200, 1'b0, 32'h0);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0204, 1'b1, 32'h8000_0200);
        vecs[16] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0208, 1'b1, 32'h8000_0200);
        vecs[17] = mk(1'b0, 1'b1, 32'h8000_0400, 1'b0, 1'b1, 32'h8000_0400, 1'b0, 32'h0);
        vecs[18] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0404, 1'b1, 32'h8000_0400);
        vecs[19] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h8000_0404, 1'b0, 32'h0);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        vecs[21] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
        vecs[22] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
        vecs[23] = mk(1'b0, 1'b1, 32'h8000_0500, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0);

        // Reset stream: one fetch per cycle, each result scoreboarded.
        do_reset();
        exp_addr = 32'h8000_0000;
        for (int k = 0; k < 8; k++) begin
            chk("stream_req",  64'(imem_req), 64'd1);
            chk("stream_addr", 64'(imem_addr), 64'(exp_addr));
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            sb_q.push_back({exp_addr ^ XOR_K, exp_addr});
            exp_addr = exp_addr + 32'd4;
            step();
            if (sb_q.size() == 0) begin
                chk("stream_sb_empty", 64'd1, 64'd0);
            end else begin
                popped = sb_q.pop_front();
                chk("stream_fs",    fs_ds_reg_data, popped);
                chk("stream_valid", 64'(fs_valid), 64'd1);
            end
        end

        // Table of single-cycle vectors covering stall, redirect, misalignment and wrap.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].lu, vecs[i].bt, vecs[i].ba, vecs[i].rdy);
            step();
            chk($sformatf("vec%0d_req", i),   64'(imem_req), 64'(vecs[i].exp_req));
            chk($sformatf("vec%0d_addr", i),  64'(imem_addr), 64'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_valid", i), 64'(fs_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_fs", i),    fs_ds_reg_data,
                exp_fs(vecs[i].exp_valid, vecs[i].exp_pc));
        end

        // Asynchronous reset while in DROP: outputs clear with no clock edge.
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("async_rst");
        #3;
        resetn = 1'b1;
        step();
        chk("async_rel_req",  64'(imem_req), 64'd1);
        chk("async_rel_addr", 64'(imem_addr), 64'h8000_0000);
        // Back in RUN: the fetch is delivered instead of being discarded as in DROP.
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("async_run_addr",  64'(imem_addr), 64'h8000_0004);
        chk("async_run_valid", 64'(fs_valid), 64'd1);
        chk("async_run_fs",    fs_ds_reg_data, exp_fs(1'b1, 32'h8000_0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
